// File: rtl/hazard_forward_if.sv
// Decode-side bundle for the hazard/forwarding controller.
// The shadow entries and hold flag are exposed for observation.
interface hazard_forward_if;
  logic       id_valid;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_is_bl;
  logic       id_uses_rm;
  logic       flush;

  logic       stall;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       forward_load;
  logic       forward_bl;

  // {valid, rd, regwrite, memread, is_bl}
  logic [8:0] ex_entry;
  logic [8:0] mem_entry;
  logic [8:0] wb_entry;
  logic       hold;

  modport master (
    output id_valid, id_rn, id_rm, id_rd,
    output id_regwrite, id_memread,
    output id_is_bl, id_uses_rm, flush,
    input  stall, forwardA, forwardB,
    input  forward_load, forward_bl,
    input  ex_entry, mem_entry, wb_entry,
    input  hold
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd,
    input  id_regwrite, id_memread,
    input  id_is_bl, id_uses_rm, flush,
    output stall, forwardA, forwardB,
    output forward_load, forward_bl,
    output ex_entry, mem_entry, wb_entry,
    output hold
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Load-use / BL stall and EX operand forwarding control,
// driven by a shadow copy of the EX, MEM and WB stages.
module hazard_forward_ctrl #(
  parameter logic [4:0] ZR = 5'd31
) (
  input logic             clk,
  input logic             reset,
  hazard_forward_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       is_bl;
  } entry_t;

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  entry_t ex_q;
  entry_t mem_q;
  entry_t wb_q;
  entry_t id_e;

  logic [1:0] fa_q;
  logic [1:0] fb_q;
  logic       fl_q;
  logic       fbl_q;

  logic [1:0] fa_nx;
  logic [1:0] fb_nx;
  logic       fl_nx;
  logic       fbl_nx;

  logic rn_ex;
  logic rm_ex;
  logic rn_mem;
  logic rm_mem;
  logic hazard;
  logic stall;
  logic advance;

  logic a_load;
  logic a_ex;
  logic a_bl;
  logic a_mem;
  logic b_ex;
  logic b_mem;

  function automatic logic hit(
    input entry_t     e,
    input logic [4:0] src
  );
    return e.valid && e.regwrite &&
           (e.rd == src) && (src != ZR);
  endfunction

  assign id_e = '{
    valid:    bus.id_valid,
    rd:       bus.id_rd,
    regwrite: bus.id_regwrite,
    memread:  bus.id_memread,
    is_bl:    bus.id_is_bl
  };

  assign rn_ex  = hit(ex_q, bus.id_rn);
  assign rm_ex  = hit(ex_q, bus.id_rm);
  assign rn_mem = hit(mem_q, bus.id_rn);
  assign rm_mem = hit(mem_q, bus.id_rm);

  // Loaded value is not ready for B; BL link value is not
  // ready for either operand until BL reaches MEM.
  assign hazard =
    (bus.id_uses_rm & rm_ex & ex_q.memread) |
    ((rn_ex | rm_ex) & ex_q.is_bl);

  assign stall = !reset && (state == RUN) &&
                 bus.id_valid && !bus.flush && hazard;

  assign advance = bus.id_valid & !stall & !bus.flush;

  assign a_load = rn_ex & ex_q.memread;
  assign a_ex   = rn_ex & !ex_q.memread;
  assign a_bl   = !rn_ex & rn_mem & mem_q.is_bl;
  assign a_mem  = !rn_ex & rn_mem & !mem_q.is_bl;

  assign b_ex  = bus.id_uses_rm & rm_ex & !ex_q.memread;
  assign b_mem = bus.id_uses_rm & !rm_ex & rm_mem;

  always_comb begin
    fa_nx  = 2'b00;
    fl_nx  = 1'b0;
    fbl_nx = 1'b0;
    if (advance) begin
      unique case (1'b1)
        a_load:  fl_nx  = 1'b1;
        a_ex:    fa_nx  = 2'b10;
        a_bl:    fbl_nx = 1'b1;
        a_mem:   fa_nx  = 2'b01;
        default: fa_nx  = 2'b00;
      endcase
    end
  end

  always_comb begin
    fb_nx = 2'b00;
    if (advance) begin
      unique case (1'b1)
        b_ex:    fb_nx = 2'b10;
        b_mem:   fb_nx = 2'b01;
        default: fb_nx = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_nx = RUN;
    if (state == RUN && stall) begin
      state_nx = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      fa_q  <= 2'b00;
      fb_q  <= 2'b00;
      fl_q  <= 1'b0;
      fbl_q <= 1'b0;
    end else begin
      state <= state_nx;
      ex_q  <= advance ? id_e : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      fa_q  <= fa_nx;
      fb_q  <= fb_nx;
      fl_q  <= fl_nx;
      fbl_q <= fbl_nx;
    end
  end

  assign bus.stall        = stall;
  assign bus.forwardA     = fa_q;
  assign bus.forwardB     = fb_q;
  assign bus.forward_load = fl_q;
  assign bus.forward_bl   = fbl_q;
  assign bus.ex_entry     = ex_q;
  assign bus.mem_entry    = mem_q;
  assign bus.wb_entry     = wb_q;
  assign bus.hold         = (state == HOLD);

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter ZR, default 31, is the zero-register index and is never a forwarding source.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 id_rn, id_rm, id_rd  input  5 each  source A, source B and destination register of the decode instruction.
REQ-006 id_regwrite, id_memread, id_is_bl, id_uses_rm  input  1 each  decode flags: writes rd, is LDUR, is BL (rd=30), reads rm.
REQ-007 flush  input  1  taken-branch squash of the decode instruction.
REQ-008 stall  output  1  hold PC and IF/ID this cycle; combinational.
REQ-009 forwardA, forwardB  output  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM result; 11 never driven.
REQ-010 forward_load  output  1  EX operand A takes MEM read_data.
REQ-011 forward_bl  output  1  EX operand A takes WB WriteData.

Function
REQ-012 The block shall keep a 3-entry shadow pipeline (EX, MEM, WB), each entry holding {valid, rd, regwrite, memread, is_bl}.
REQ-013 Each cycle, MEM<=EX and WB<=MEM; EX<=decode entry when advance=id_valid&!stall&!flush, else EX<=bubble (valid=0).
REQ-014 A source "matches" an entry only if valid & regwrite & rd==source & source!=ZR.
REQ-015 Forward outputs are registered: on an advancing edge they are computed for the decode instruction; on any non-advancing edge they are all 0.
REQ-016 A-operand priority, evaluated against pre-edge entries: EX-entry match with memread -> forward_load=1; EX-entry match without memread -> forwardA=10; else MEM-entry match with is_bl -> forward_bl=1; else MEM-entry match -> forwardA=01; else 00.
REQ-017 B-operand, only if id_uses_rm: EX-entry match (non-load) -> forwardB=10; else MEM-entry match -> forwardB=01; else 00.
REQ-018 At most one of forward_load, forward_bl, forwardA!=00 shall be asserted at once.
REQ-019 stall shall be 1 when id_valid & !flush and either (id_uses_rm and rm matches a memread EX entry) or (rn or rm matches an is_bl EX entry).
REQ-020 FSM states RUN, HOLD: RUN->HOLD when stall; HOLD->RUN next edge (hazard entry has moved to MEM, so stall then evaluates 0); a hazard therefore costs exactly one bubble.
REQ-021 While in HOLD the decode inputs are held stable by the upstream IF/ID register; the block shall not latch them.
REQ-022 flush shall force stall=0, EX<=bubble, state<=RUN, and clear the forward outputs on that edge; existing MEM/WB entries still shift.
REQ-023 A decode instruction with rn==rm matching the same entry shall get identical A and B selections (except load/BL cases per REQ-016/019).
REQ-024 id_valid=0 shall produce a bubble and forward outputs of 0.

Reset
REQ-025 On reset, all shadow entries shall be invalid, state=RUN, stall=0, forwardA=forwardB=00, forward_load=forward_bl=0.
REQ-026 Reset asserted mid-HOLD shall return to RUN on that edge with no further stall.

Verification
REQ-027 ADD X1 then ADD X2,X1,X3 back-to-back -> second instruction in EX sees forwardA=10, stall never 1.
REQ-028 ADD X1; NOP; SUB X4,X5,X1 -> forwardB=01 for SUB; with a second writer of X1 in the slot between, forwardB=10 (MEM priority).
REQ-029 LDUR X9; ADD X2,X9,X3 -> no stall, forward_load=1; LDUR X9; ADD X2,X3,X9 -> stall=1 one cycle, one bubble, then forwardB=01.
REQ-030 BL (X30); ADD X1,X30,X2 -> one-cycle stall, then forward_bl=1, forwardA=00.
REQ-031 ADD X31,...; ADD X2,X31,X31 -> all forward outputs 0; flush during LDUR-use stall -> stall drops same cycle, state RUN.
REQ-032 Reset asserted during HOLD -> all outputs 0 next cycle, shadow entries invalid.
